// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands/control, forwards from
// EX/MEM and MEM/WB into the ALU operands, and detects load-use hazards.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [1:0]  id_uses,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_shamt,
    input  logic [2:0]  id_alu_ctl,
    input  logic [4:0]  id_ctrl,
    input  logic        flush,
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_data,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_data,
    output logic        stall,
    output logic        ex_valid,
    output logic [3:0]  ex_ctrl,
    output logic [4:0]  ex_rd,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_ctl,
    output logic [4:0]  alu_shamt,
    output logic [31:0] ex_store_data
);

    // Handshake: ID offers an instruction with id_valid; it is accepted on a
    // rising edge only when stall and flush are both low, otherwise a bubble
    // (ex_valid = 0, all control 0) enters EX and ID must hold its contents.

    logic        ex_valid_q,  ex_valid_d;
    logic [3:0]  ex_ctrl_q,   ex_ctrl_d;
    logic        alu_src_q,   alu_src_d;
    logic [4:0]  ex_rd_q,     ex_rd_d;
    logic [4:0]  rs_q,        rs_d;
    logic [4:0]  rt_q,        rt_d;
    logic [31:0] rs_data_q,   rs_data_d;
    logic [31:0] rt_data_q,   rt_data_d;
    logic [31:0] imm_q,       imm_d;
    logic [4:0]  shamt_q,     shamt_d;
    logic [2:0]  alu_ctl_q,   alu_ctl_d;

    logic        load_in_ex;
    logic        rs_hit;
    logic        rt_hit;
    logic        stall_c;
    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;

    // ex_ctrl bit 2 is mem_read: only a live load in EX can cause a stall.
    always_comb begin
        load_in_ex = ex_valid_q & ex_ctrl_q[2] & (ex_rd_q != 5'd0);
        rs_hit     = id_uses[1] & (id_rs == ex_rd_q);
        rt_hit     = id_uses[0] & (id_rt == ex_rd_q);
        stall_c    = id_valid & load_in_ex & (rs_hit | rt_hit) & ~flush;
    end

    always_comb begin
        ex_valid_d = 1'b0;
        ex_ctrl_d  = 4'd0;
        alu_src_d  = 1'b0;
        ex_rd_d    = 5'd0;
        rs_d       = 5'd0;
        rt_d       = 5'd0;
        rs_data_d  = 32'd0;
        rt_data_d  = 32'd0;
        imm_d      = 32'd0;
        shamt_d    = 5'd0;
        alu_ctl_d  = 3'd0;
        if (!(flush || stall_c)) begin
            ex_valid_d = id_valid;
            ex_ctrl_d  = id_ctrl[3:0];
            alu_src_d  = id_ctrl[4];
            ex_rd_d    = id_rd;
            rs_d       = id_rs;
            rt_d       = id_rt;
            rs_data_d  = id_rs_data;
            rt_data_d  = id_rt_data;
            imm_d      = id_imm;
            shamt_d    = id_shamt;
            alu_ctl_d  = id_alu_ctl;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= 4'd0;
            alu_src_q  <= 1'b0;
            ex_rd_q    <= 5'd0;
            rs_q       <= 5'd0;
            rt_q       <= 5'd0;
            rs_data_q  <= 32'd0;
            rt_data_q  <= 32'd0;
            imm_q      <= 32'd0;
            shamt_q    <= 5'd0;
            alu_ctl_q  <= 3'd0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_ctrl_q  <= ex_ctrl_d;
            alu_src_q  <= alu_src_d;
            ex_rd_q    <= ex_rd_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rs_data_q  <= rs_data_d;
            rt_data_q  <= rt_data_d;
            imm_q      <= imm_d;
            shamt_q    <= shamt_d;
            alu_ctl_q  <= alu_ctl_d;
        end
    end

    // The younger producer (EX/MEM) wins; $0 always keeps its captured value.
    always_comb begin
        if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rs_q)) begin
            fwd_rs = exmem_data;
        end else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rs_q)) begin
            fwd_rs = memwb_data;
        end else begin
            fwd_rs = rs_data_q;
        end
    end

    always_comb begin
        if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rt_q)) begin
            fwd_rt = exmem_data;
        end else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rt_q)) begin
            fwd_rt = memwb_data;
        end else begin
            fwd_rt = rt_data_q;
        end
    end

    assign stall         = stall_c;
    assign ex_valid      = ex_valid_q;
    assign ex_ctrl       = ex_ctrl_q;
    assign ex_rd         = ex_rd_q;
    assign alu_a         = fwd_rs;
    assign alu_b         = alu_src_q ? imm_q : fwd_rt;
    assign alu_ctl       = alu_ctl_q;
    assign alu_shamt     = shamt_q;
    assign ex_store_data = fwd_rt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard scenarios plus random traffic, all
// checked against an instruction-level model of what EX should hold.
module tb_id_ex_stage;

    localparam int W = 115;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [1:0]  id_uses;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    logic [4:0]  id_shamt;
    logic [2:0]  id_alu_ctl;
    logic [4:0]  id_ctrl;
    logic        flush;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_data;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_data;
    logic        stall;
    logic        ex_valid;
    logic [3:0]  ex_ctrl;
    logic [4:0]  ex_rd;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctl;
    logic [4:0]  alu_shamt;
    logic [31:0] ex_store_data;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_uses(id_uses), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_imm(id_imm), .id_shamt(id_shamt),
        .id_alu_ctl(id_alu_ctl), .id_ctrl(id_ctrl), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .stall(stall), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_rd(ex_rd),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl), .alu_shamt(alu_shamt),
        .ex_store_data(ex_store_data)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- counters and checker ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: the instruction sitting in EX ----------------
    typedef struct {
        logic        valid;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rs_val, rt_val, imm;
        logic [4:0]  shamt;
        logic [2:0]  op;
        logic        alu_src;
        logic [3:0]  ctrl;
    } ex_rec_t;

    ex_rec_t ex_m;

    function automatic ex_rec_t bubble();
        ex_rec_t r;
        r.valid = 1'b0; r.rs = 0; r.rt = 0; r.rd = 0;
        r.rs_val = 0; r.rt_val = 0; r.imm = 0;
        r.shamt = 0; r.op = 0; r.alu_src = 1'b0; r.ctrl = 0;
        return r;
    endfunction

    function automatic ex_rec_t from_id();
        ex_rec_t r;
        r.valid = id_valid; r.rs = id_rs; r.rt = id_rt; r.rd = id_rd;
        r.rs_val = id_rs_data; r.rt_val = id_rt_data; r.imm = id_imm;
        r.shamt = id_shamt; r.op = id_alu_ctl; r.alu_src = id_ctrl[4];
        r.ctrl = id_ctrl[3:0];
        return r;
    endfunction

    // Value the instruction would see for a source register right now.
    function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] captured);
        if (r == 0) return captured;
        if (exmem_reg_write && exmem_rd == r) return exmem_data;
        if (memwb_reg_write && memwb_rd == r) return memwb_data;
        return captured;
    endfunction

    // The ID instruction must wait if it reads the register a load in EX is fetching.
    function automatic logic model_stall();
        logic is_load;
        is_load = ex_m.valid && ex_m.ctrl[2] && ex_m.rd != 0;
        if (!id_valid || !is_load || flush) return 1'b0;
        return (id_uses[1] && id_rs == ex_m.rd) || (id_uses[0] && id_rt == ex_m.rd);
    endfunction

    function automatic logic [W-1:0] model_outputs();
        logic [31:0] a, bt, b;
        a  = operand(ex_m.rs, ex_m.rs_val);
        bt = operand(ex_m.rt, ex_m.rt_val);
        b  = ex_m.alu_src ? ex_m.imm : bt;
        return {model_stall(), ex_m.valid, ex_m.ctrl, ex_m.rd, ex_m.op, ex_m.shamt, a, b, bt};
    endfunction

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("stall",     {31'd0, stall},         {31'd0, e[114]});
            check("ex_valid",  {31'd0, ex_valid},      {31'd0, e[113]});
            check("ex_ctrl",   {28'd0, ex_ctrl},       {28'd0, e[112:109]});
            check("ex_rd",     {27'd0, ex_rd},         {27'd0, e[108:104]});
            check("alu_ctl",   {29'd0, alu_ctl},       {29'd0, e[103:101]});
            check("alu_shamt", {27'd0, alu_shamt},     {27'd0, e[100:96]});
            check("alu_a",     alu_a,                  e[95:64]);
            check("alu_b",     alu_b,                  e[63:32]);
            check("store",     ex_store_data,          e[31:0]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [1:0] uses,
                          input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [31:0] imm, input logic [4:0] sh,
                          input logic [2:0] op, input logic [4:0] ctrl);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_uses = uses;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_shamt = sh;
        id_alu_ctl = op; id_ctrl = ctrl;
    endtask

    task automatic set_fwd(input logic xw, input logic [4:0] xr, input logic [31:0] xd,
                           input logic ww, input logic [4:0] wr, input logic [31:0] wd);
        exmem_reg_write = xw; exmem_rd = xr; exmem_data = xd;
        memwb_reg_write = ww; memwb_rd = wr; memwb_data = wd;
    endtask

    task automatic idle();
        set_id(1'b0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3'd0, 5'd0);
    endtask

    task automatic randomize_inputs();
        set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 2'($urandom), $urandom, $urandom, $urandom,
               5'($urandom), 3'($urandom), 5'($urandom));
        set_fwd(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom), 5'($urandom_range(0, 7)), $urandom);
        flush = ($urandom_range(0, 7) == 0);
    endtask

    // Publish the expected outputs for this cycle, then advance the model one edge.
    task automatic step();
        ex_rec_t nxt;
        exp_q.push_back(model_outputs());
        nxt = (flush || model_stall()) ? bubble() : from_id();
        @(posedge clk);
        #1;
        ex_m = nxt;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"},    {31'd0, stall},     32'd0);
        check({tag, "_valid"},    {31'd0, ex_valid},  32'd0);
        check({tag, "_ctrl"},     {28'd0, ex_ctrl},   32'd0);
        check({tag, "_rd"},       {27'd0, ex_rd},     32'd0);
        check({tag, "_alu_ctl"},  {29'd0, alu_ctl},   32'd0);
        check({tag, "_shamt"},    {27'd0, alu_shamt}, 32'd0);
        check({tag, "_alu_a"},    alu_a,              32'd0);
        check({tag, "_alu_b"},    alu_b,              32'd0);
        check({tag, "_store"},    ex_store_data,      32'd0);
    endtask

    localparam logic [4:0] CTRL_LW  = 5'b11101;
    localparam logic [4:0] CTRL_ADD = 5'b01000;

    // ---------------- stimulus ----------------
    initial begin
        ex_m = bubble();
        rst = 1'b1;
        randomize_inputs();
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        randomize_inputs();
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        ex_m = bubble();
        flush = 1'b0;

        // EX/MEM wins over MEM/WB for the same register.
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 5, 6, 9, 2'b11, 32'h1111, 32'h2222, 32'h0, 5'd0, 3'b010, CTRL_ADD);
        step();
        idle();
        set_fwd(1, 5, 32'hAAAA_0001, 1, 5, 32'h5555_0002);
        #1 check("prio_alu_a", alu_a, 32'hAAAA_0001);
        step();

        // MEM/WB forward on rt while alu_b takes the immediate.
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 1, 7, 10, 2'b11, 32'h0, 32'h0BAD, 32'hFFFF_FFFC, 5'd0, 3'b010, 5'b11000);
        step();
        idle();
        set_fwd(0, 0, 0, 1, 7, 32'h0000_0123);
        #1;
        check("imm_alu_b", alu_b, 32'hFFFF_FFFC);
        check("imm_store", ex_store_data, 32'h0000_0123);
        step();

        // Register zero is never forwarded; a load to $0 never stalls.
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 0, 2, 11, 2'b11, 32'h0, 32'h4, 32'h0, 5'd0, 3'b010, CTRL_ADD);
        step();
        idle();
        set_fwd(1, 0, 32'hDEAD_BEEF, 1, 0, 32'h0000_BEEF);
        #1 check("r0_alu_a", alu_a, 32'd0);
        step();
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 4, 4, 0, 2'b10, 32'h100, 32'h0, 32'h8, 5'd0, 3'b010, CTRL_LW);
        step();
        set_id(1, 0, 0, 3, 2'b11, 32'h0, 32'h0, 32'h0, 5'd0, 3'b010, CTRL_ADD);
        #1 check("r0_load_stall", {31'd0, stall}, 32'd0);
        step();

        // Load-use: lw $8 then add reading $8.
        set_id(1, 1, 0, 8, 2'b10, 32'h200, 32'h0, 32'h10, 5'd0, 3'b010, CTRL_LW);
        step();
        set_id(1, 8, 3, 12, 2'b11, 32'h0, 32'h33, 32'h0, 5'd0, 3'b010, CTRL_ADD);
        #1 check("lu_stall_on", {31'd0, stall}, 32'd1);
        step();
        set_fwd(1, 8, 32'h0000_0210, 0, 0, 0);
        #1;
        check("lu_stall_off", {31'd0, stall}, 32'd0);
        check("lu_bubble", {31'd0, ex_valid}, 32'd0);
        step();
        idle();
        set_fwd(0, 0, 0, 1, 8, 32'hCAFE_0008);
        #1;
        check("lu_add_valid", {31'd0, ex_valid}, 32'd1);
        check("lu_alu_a", alu_a, 32'hCAFE_0008);
        step();

        // Flush beats a load-use condition in the same cycle.
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 1, 0, 8, 2'b10, 32'h200, 32'h0, 32'h10, 5'd0, 3'b010, CTRL_LW);
        step();
        set_id(1, 8, 3, 12, 2'b11, 32'h0, 32'h33, 32'h0, 5'd0, 3'b010, CTRL_ADD);
        flush = 1'b1;
        #1 check("flush_stall", {31'd0, stall}, 32'd0);
        step();
        flush = 1'b0;
        idle();
        #1 check("flush_bubble", {31'd0, ex_valid}, 32'd0);
        step();

        // Asynchronous reset in the middle of a stall.
        set_id(1, 1, 0, 9, 2'b10, 32'h300, 32'h0, 32'h4, 5'd3, 3'b010, CTRL_LW);
        step();
        set_id(1, 9, 9, 13, 2'b11, 32'h0, 32'h0, 32'h0, 5'd0, 3'b010, CTRL_ADD);
        #1 check("arst_pre_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        set_fwd(1, 9, 32'h1234_5678, 1, 9, 32'h8765_4321);
        #1 check_all_zero("arst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        ex_m = bubble();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            step();
        end
        idle();
        flush = 1'b0;
        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
